// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-byte memory.
// Every output comes straight from a flop.
module mem_arbiter #(
  parameter int STORE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [1:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [1:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] rdata,
  output logic [1:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_store,
  input  logic [7:0] mem_q,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(STORE_CYCLES - 1);

  state_t     r_state;
  state_t     w_nxt;
  logic       r_we;
  logic       r_last;
  logic [3:0] r_cnt;

  logic w_grant;
  logic w_pick_b;
  logic w_load;
  logic w_store_end;
  logic w_busy_d;
  logic w_store_d;
  logic w_aack_d;
  logic w_back_d;

  assign w_grant     = a_req | b_req;
  // r_last = 1 means B was granted last, so A wins a tie
  assign w_pick_b    = b_req & (~a_req | ~r_last);
  assign w_load      = (r_state == S_IDLE) & w_grant;
  assign w_store_end = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_nxt = S_SETUP;
      S_SETUP: w_nxt = r_we ? S_WRITE : S_READ;
      S_WRITE: if (w_store_end) w_nxt = S_DONE;
      S_READ:  w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_d  = (w_nxt != S_IDLE);
    w_store_d = (w_nxt == S_WRITE);
    w_aack_d  = (w_nxt == S_DONE) & ~owner;
    w_back_d  = (w_nxt == S_DONE) & owner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      mem_store <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
    end else begin
      busy      <= w_busy_d;
      mem_store <= w_store_d;
      a_ack     <= w_aack_d;
      b_ack     <= w_back_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= 1'b0;
      r_we     <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= 4'd0;
      mem_addr <= 2'd0;
      mem_data <= 8'd0;
      rdata    <= 8'd0;
    end else begin
      if (w_load) begin
        owner    <= w_pick_b;
        r_we     <= w_pick_b ? b_we : a_we;
        mem_addr <= w_pick_b ? b_addr : a_addr;
        mem_data <= w_pick_b ? b_wdata : a_wdata;
      end
      if (r_state == S_READ) begin
        rdata <= mem_q;
      end
      if (r_state == S_WRITE) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      if (r_state == S_DONE) begin
        r_last <= owner;
      end
    end
  end

endmodule
